// File: rtl/mac_pkg.sv
// Shared types and constants for the 2x2 MAC array job sequencer.
// Holds FSM states, job modes and the wavefront tap table.
package mac_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      CLEAR,
      STREAM,
      DRAIN,
      RESULT
   } state_e;

   localparam logic MODE_STREAM = 1'b0;
   localparam logic MODE_CHAIN  = 1'b1;

   // Per-MAC tap into the wavefront register (tap n = delay n+1).
   // STREAM ring 0->1->3->2: delays 1,2,4,3 for MACs 0..3.
   localparam logic [3:0][1:0] WF_TAP_STREAM =
      {2'd2, 2'd3, 2'd1, 2'd0};
   // CHAIN: MAC0 at d1, MAC1/MAC2 at d2, MAC3 at d3.
   localparam logic [3:0][1:0] WF_TAP_CHAIN =
      {2'd2, 2'd1, 2'd1, 2'd0};

endpackage

// File: rtl/mac_array_ctrl_wavefront.sv
// Beat wavefront: 4-deep shift of accepted beats, mapped per mode
// onto the valid_in_0 (STREAM) or valid_in_1 (CHAIN) vectors.
module mac_wavefront
   import mac_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       mode_i,
   input  logic       fire_i,
   output logic [3:0] vin0_o,
   output logic [3:0] vin1_o,
   output logic       empty_o
);

   logic [3:0] wf_q;
   logic [3:0] wf_d;

   assign wf_d    = {wf_q[2:0], fire_i};
   assign empty_o = ~|wf_q;

   // Shift one accepted-beat marker per cycle; bubbles shift as zeros
   always_ff @(posedge clk or posedge rst) begin
      if (rst) wf_q <= '0;
      else     wf_q <= wf_d;
   end

   // Route each MAC's delay tap to the valid vector of the active mode
   always_comb begin
      vin0_o = '0;
      vin1_o = '0;
      for (int i = 0; i < 4; i++) begin
         if (mode_i == MODE_CHAIN)
            vin1_o[i] = wf_q[WF_TAP_CHAIN[i]];
         else
            vin0_o[i] = wf_q[WF_TAP_STREAM[i]];
      end
   end

endmodule

// File: rtl/mac_array_ctrl.sv
// Job sequencer for the 2x2 mac_array: weight load, clear,
// activation streaming with valid wavefronts, result gather.
module mac_array_ctrl
   import mac_pkg::*;
#(
   parameter int W        = 8,
   parameter int ACC_W    = 16,
   parameter int N_MACS   = 4,
   parameter int K_W      = 8,
   parameter int DRAIN_TO = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  job_valid,
   output logic                  job_ready,
   input  logic                  job_mode,
   input  logic [K_W-1:0]        job_k,
   input  logic                  w_valid,
   output logic                  w_ready,
   input  logic [W-1:0]          w_data,
   input  logic                  act_valid,
   output logic                  act_ready,
   input  logic [W-1:0]          act_data,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [4*ACC_W-1:0]    res_data,
   output logic                  res_err,
   output logic [W-1:0]          arr_a_in,
   output logic [W-1:0]          arr_w0,
   output logic [W-1:0]          arr_w1,
   output logic [W-1:0]          arr_w2,
   output logic [W-1:0]          arr_w3,
   output logic [N_MACS-1:0]     arr_vin0,
   output logic [N_MACS-1:0]     arr_vin1,
   output logic [N_MACS-1:0]     arr_vin2,
   output logic [N_MACS-1:0]     arr_clear,
   input  logic [N_MACS-1:0]     arr_vout,
   input  logic [ACC_W-1:0]      arr_acc0,
   input  logic [ACC_W-1:0]      arr_acc1,
   input  logic [ACC_W-1:0]      arr_acc2,
   input  logic [ACC_W-1:0]      arr_acc3,
   output logic                  busy
);

   if (N_MACS != 4) begin : g_bad_n_macs
      $error("mac_array_ctrl: N_MACS must be 4");
   end

   localparam int DCW = $clog2(DRAIN_TO + 1);

   state_e           state_q, state_d;
   logic             mode_q;
   logic [K_W-1:0]   beats_q;
   logic [1:0]       wcnt_q;
   logic [W-1:0]     w0_q, w1_q, w2_q, w3_q;
   logic [W-1:0]     a_q;
   logic [3:0]       seen_q;
   logic [DCW-1:0]   dcnt_q;
   logic [ACC_W-1:0] acc0_q, acc1_q, acc2_q, acc3_q;
   logic             err_q;

   logic             job_fire, w_fire, act_fire, res_fire;
   logic             capture, wf_empty;
   logic             drain_done, drain_to;
   logic [3:0]       vin0_w, vin1_w;

   assign job_fire = job_valid & job_ready;
   assign w_fire   = w_valid & w_ready;
   assign act_fire = act_valid & act_ready;
   assign res_fire = res_valid & res_ready;

   assign capture    = (state_q == STREAM) || (state_q == DRAIN);
   assign drain_done = (&(seen_q | arr_vout)) && wf_empty;
   assign drain_to   = dcnt_q == DCW'(DRAIN_TO - 1);

   mac_wavefront u_wf (
      .clk     (clk),
      .rst     (rst),
      .mode_i  (mode_q),
      .fire_i  (act_fire),
      .vin0_o  (vin0_w),
      .vin1_o  (vin1_w),
      .empty_o (wf_empty)
   );

   assign arr_vin0 = vin0_w;
   assign arr_vin1 = vin1_w;
   assign arr_vin2 = '0;
   assign arr_a_in = a_q;
   assign arr_w0   = w0_q;
   assign arr_w1   = w1_q;
   assign arr_w2   = w2_q;
   assign arr_w3   = w3_q;
   assign res_data = {acc3_q, acc2_q, acc1_q, acc0_q};
   assign res_err  = err_q;

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:
            if (job_fire) state_d = LOAD_W;
         LOAD_W:
            if (w_fire && wcnt_q == 2'd3) state_d = CLEAR;
         CLEAR:
            state_d = STREAM;
         STREAM:
            if (beats_q == '0 ||
                (act_fire && beats_q == K_W'(1)))
               state_d = DRAIN;
         DRAIN:
            if (drain_done || drain_to) state_d = RESULT;
         RESULT:
            if (res_fire) state_d = IDLE;
         default:
            state_d = IDLE;
      endcase
   end

   // FSM outputs decoded from the current state
   always_comb begin
      job_ready = state_q == IDLE;
      w_ready   = state_q == LOAD_W;
      act_ready = (state_q == STREAM) && (beats_q != '0);
      arr_clear = (state_q == CLEAR) ? '1 : '0;
      res_valid = state_q == RESULT;
      busy      = state_q != IDLE;
   end

   // Job mode and remaining-beat counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q  <= MODE_STREAM;
         beats_q <= '0;
      end else if (job_fire) begin
         mode_q  <= job_mode;
         beats_q <= job_k;
      end else if (act_fire) begin
         beats_q <= beats_q - K_W'(1);
      end
   end

   // Weight load: beat n goes to w_n, held until the next job's load
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wcnt_q <= '0;
         w0_q   <= '0;
         w1_q   <= '0;
         w2_q   <= '0;
         w3_q   <= '0;
      end else if (w_fire) begin
         wcnt_q <= wcnt_q + 2'd1;
         unique case (wcnt_q)
            2'd0: w0_q <= w_data;
            2'd1: w1_q <= w_data;
            2'd2: w2_q <= w_data;
            default: w3_q <= w_data;
         endcase
      end
   end

   // Activation register feeding a_in one cycle after accept
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           a_q <= '0;
      else if (act_fire) a_q <= act_data;
   end

   // Completion tracking: seen mask and drain cycle counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seen_q <= '0;
         dcnt_q <= '0;
      end else if (state_q == CLEAR) begin
         seen_q <= (beats_q == '0) ? 4'hF : 4'h0;
         dcnt_q <= '0;
      end else if (capture) begin
         seen_q <= seen_q | arr_vout;
         if (state_q == DRAIN) dcnt_q <= dcnt_q + DCW'(1);
      end
   end

   // Result gather: latch each acc on its valid_out, last one wins
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc0_q <= '0;
         acc1_q <= '0;
         acc2_q <= '0;
         acc3_q <= '0;
         err_q  <= 1'b0;
      end else if (state_q == CLEAR || res_fire) begin
         acc0_q <= '0;
         acc1_q <= '0;
         acc2_q <= '0;
         acc3_q <= '0;
         err_q  <= 1'b0;
      end else if (capture) begin
         if (arr_vout[0]) acc0_q <= arr_acc0;
         if (arr_vout[1]) acc1_q <= arr_acc1;
         if (arr_vout[2]) acc2_q <= arr_acc2;
         if (arr_vout[3]) acc3_q <= arr_acc3;
         if (state_q == DRAIN && drain_to && !drain_done)
            err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Directed bench for mac_array_ctrl with a behavioural MAC array
// stand-in, a result scoreboard and a continuous wavefront check.
module tb_mac_array_ctrl;

   localparam int W     = 8;
   localparam int ACC_W = 16;
   localparam int K_W   = 8;
   localparam int DTO   = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             job_valid, job_ready, job_mode;
   logic [K_W-1:0]   job_k;
   logic             w_valid, w_ready;
   logic [W-1:0]     w_data;
   logic             act_valid, act_ready;
   logic [W-1:0]     act_data;
   logic             res_valid, res_ready;
   logic [4*ACC_W-1:0] res_data;
   logic             res_err;
   logic [W-1:0]     arr_a_in, arr_w0, arr_w1, arr_w2, arr_w3;
   logic [3:0]       arr_vin0, arr_vin1, arr_vin2, arr_clear;
   logic [3:0]       arr_vout;
   logic [ACC_W-1:0] arr_acc0, arr_acc1, arr_acc2, arr_acc3;
   logic             busy;

   int n_cmp = 0;
   int n_bad = 0;
   logic [64:0] sb_q[$];

   logic [3:0]       vout_raw;
   logic [3:0]       vout_mask;
   logic [ACC_W-1:0] macc [4];
   logic [W-1:0]     wv [4];
   logic             cur_mode;
   logic [7:0]       hist;
   logic [3:0]       e0, e1;

   always #5 clk = ~clk;

   mac_array_ctrl dut (
      .clk(clk), .rst(rst),
      .job_valid(job_valid), .job_ready(job_ready),
      .job_mode(job_mode), .job_k(job_k),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
      .act_valid(act_valid), .act_ready(act_ready),
      .act_data(act_data),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_err(res_err),
      .arr_a_in(arr_a_in),
      .arr_w0(arr_w0), .arr_w1(arr_w1),
      .arr_w2(arr_w2), .arr_w3(arr_w3),
      .arr_vin0(arr_vin0), .arr_vin1(arr_vin1),
      .arr_vin2(arr_vin2), .arr_clear(arr_clear),
      .arr_vout(arr_vout),
      .arr_acc0(arr_acc0), .arr_acc1(arr_acc1),
      .arr_acc2(arr_acc2), .arr_acc3(arr_acc3),
      .busy(busy)
   );

   assign wv[0] = arr_w0;
   assign wv[1] = arr_w1;
   assign wv[2] = arr_w2;
   assign wv[3] = arr_w3;
   assign arr_acc0 = macc[0];
   assign arr_acc1 = macc[1];
   assign arr_acc2 = macc[2];
   assign arr_acc3 = macc[3];
   assign arr_vout = vout_raw & vout_mask;

   // Stand-in array: each valid pulse adds that MAC's weight, valid_out one cycle later
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         vout_raw <= '0;
         for (int i = 0; i < 4; i++) macc[i] <= '0;
      end else begin
         vout_raw <= arr_vin0 | arr_vin1 | arr_vin2;
         for (int i = 0; i < 4; i++) begin
            if (arr_clear[i])
               macc[i] <= '0;
            else if (arr_vin0[i] | arr_vin1[i])
               macc[i] <= macc[i] + ACC_W'(wv[i]);
         end
      end
   end

   // History of accepted beats, bit n = accepted n+1 cycles ago
   always @(posedge clk or posedge rst) begin
      if (rst) hist <= '0;
      else     hist <= {hist[6:0], act_valid & act_ready};
   end

   task automatic chk(input string tag,
                      input logic [64:0] obs,
                      input logic [64:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected wavefront from the beat history and the job mode
   always @(negedge clk) begin
      if (!rst) begin
         e0 = '0;
         e1 = '0;
         if (cur_mode)
            e1 = {hist[2], hist[1], hist[1], hist[0]};
         else
            e0 = {hist[2], hist[3], hist[1], hist[0]};
         chk("vin0", 65'(arr_vin0), 65'(e0));
         chk("vin1", 65'(arr_vin1), 65'(e1));
         chk("vin2", 65'(arr_vin2), 65'(0));
      end
   end

   function automatic logic sel(input int s);
      case (s)
         0: return job_ready;
         1: return w_ready;
         2: return act_ready;
         default: return res_valid;
      endcase
   endfunction

   task automatic wait_for(input int s, input string tag);
      int n = 0;
      while (!sel(s) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!sel(s)) begin
         n_cmp++;
         n_bad++;
         $error("FAIL %s timeout observed=0 expected=1", tag);
      end
   endtask

   task automatic start_job(input logic m, input int k);
      cur_mode  = m;
      job_mode  = m;
      job_k     = K_W'(k);
      job_valid = 1'b1;
      wait_for(0, "job_ready");
      @(negedge clk);
      job_valid = 1'b0;
   endtask

   task automatic load_w(input logic [7:0] a, b, c, d);
      logic [7:0] ws[4];
      ws[0] = a; ws[1] = b; ws[2] = c; ws[3] = d;
      for (int i = 0; i < 4; i++) begin
         w_valid = 1'b1;
         w_data  = ws[i];
         wait_for(1, "w_ready");
         @(negedge clk);
      end
      w_valid = 1'b0;
   endtask

   task automatic send_act(input logic [7:0] d);
      act_valid = 1'b1;
      act_data  = d;
      wait_for(2, "act_ready");
      @(negedge clk);
      act_valid = 1'b0;
      chk("a_in", 65'(arr_a_in), 65'(d));
   endtask

   task automatic push_exp(input logic err,
                           input int a3, a2, a1, a0);
      sb_q.push_back({err, ACC_W'(a3), ACC_W'(a2),
                      ACC_W'(a1), ACC_W'(a0)});
   endtask

   task automatic get_result(input int hold);
      logic [64:0] first;
      logic [64:0] exp;
      wait_for(3, "res_valid");
      first = {res_err, res_data};
      repeat (hold) begin
         @(negedge clk);
         chk("res_hold", {res_err, res_data}, first);
         chk("hold_jrdy", 65'(job_ready), 65'(0));
         chk("hold_rv", 65'(res_valid), 65'(1));
      end
      if (sb_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $error("FAIL sb_empty observed=0 expected=1");
      end else begin
         exp = sb_q.pop_front();
         chk("result", {res_err, res_data}, exp);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("res_clr", {res_err, res_data}, 65'(0));
      chk("rv_drop", 65'(res_valid), 65'(0));
      chk("idle_jrdy", 65'(job_ready), 65'(1));
   endtask

   initial begin
      int n;
      rst = 1'b1;
      cur_mode = 1'b0;
      job_valid = 1'b0; job_mode = 1'b0; job_k = '0;
      w_valid = 1'b0; w_data = '0;
      act_valid = 1'b0; act_data = '0;
      res_ready = 1'b0;
      vout_mask = 4'hF;
      repeat (2) @(negedge clk);

      chk("rst_jrdy", 65'(job_ready), 65'(1));
      chk("rst_wrdy", 65'(w_ready), 65'(0));
      chk("rst_ardy", 65'(act_ready), 65'(0));
      chk("rst_rv", 65'(res_valid), 65'(0));
      chk("rst_res", {res_err, res_data}, 65'(0));
      chk("rst_clr", 65'(arr_clear), 65'(0));
      chk("rst_busy", 65'(busy), 65'(0));
      chk("rst_w", 65'({arr_w3, arr_w2, arr_w1, arr_w0}), 65'(0));
      chk("rst_a", 65'(arr_a_in), 65'(0));
      rst = 1'b0;
      @(negedge clk);

      // STREAM, k=3, back-to-back beats
      start_job(1'b0, 3);
      chk("busy", 65'(busy), 65'(1));
      chk("jrdy_busy", 65'(job_ready), 65'(0));
      load_w(8'd1, 8'd2, 8'd3, 8'd4);
      chk("clear", 65'(arr_clear), 65'(4'hF));
      chk("weights", 65'({arr_w3, arr_w2, arr_w1, arr_w0}),
          65'(32'h04030201));
      push_exp(1'b0, 12, 9, 6, 3);
      send_act(8'd5);
      send_act(8'd6);
      send_act(8'd7);
      get_result(0);
      chk("w_kept", 65'({arr_w3, arr_w2, arr_w1, arr_w0}),
          65'(32'h04030201));

      // CHAIN, k=2, two bubble cycles between beats
      start_job(1'b1, 2);
      load_w(8'd10, 8'd20, 8'd30, 8'd40);
      push_exp(1'b0, 80, 60, 40, 20);
      send_act(8'd9);
      repeat (2) @(negedge clk);
      send_act(8'd11);
      get_result(0);

      // k=0: STREAM and DRAIN pass through, result stays zero
      start_job(1'b0, 0);
      load_w(8'd5, 8'd5, 8'd5, 8'd5);
      chk("k0_clear", 65'(arr_clear), 65'(4'hF));
      n = 0;
      while (!res_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("k0_lat", 65'(n), 65'(3));
      push_exp(1'b0, 0, 0, 0, 0);
      get_result(0);

      // MAC2 never reports valid_out: drain timeout
      vout_mask = 4'b1011;
      start_job(1'b0, 2);
      load_w(8'd1, 8'd1, 8'd1, 8'd1);
      push_exp(1'b1, 2, 0, 2, 2);
      send_act(8'd1);
      send_act(8'd2);
      n = 1;
      while (!res_valid && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("drain_to", 65'(n), 65'(DTO + 1));
      get_result(0);
      vout_mask = 4'hF;

      // Result held under back-pressure
      start_job(1'b0, 1);
      load_w(8'd7, 8'd8, 8'd9, 8'd10);
      push_exp(1'b0, 10, 9, 8, 7);
      send_act(8'd3);
      get_result(5);

      // Reset in the middle of a 4-beat job
      start_job(1'b0, 4);
      load_w(8'd2, 8'd2, 8'd2, 8'd2);
      send_act(8'd1);
      send_act(8'd2);
      chk("mid_busy", 65'(busy), 65'(1));
      #1 rst = 1'b1;
      #1;
      chk("arst_jrdy", 65'(job_ready), 65'(1));
      chk("arst_clr", 65'(arr_clear), 65'(0));
      chk("arst_vin",
          65'({arr_vin2, arr_vin1, arr_vin0}), 65'(0));
      chk("arst_ardy", 65'(act_ready), 65'(0));
      chk("arst_busy", 65'(busy), 65'(0));
      chk("arst_w", 65'({arr_w3, arr_w2, arr_w1, arr_w0}), 65'(0));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      start_job(1'b0, 2);
      load_w(8'd3, 8'd4, 8'd5, 8'd6);
      push_exp(1'b0, 12, 10, 8, 6);
      send_act(8'd4);
      send_act(8'd4);
      get_result(0);

      chk("sb_drained", 65'(sb_q.size()), 65'(0));
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
